// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: FSM encodings,
// register-file constants and the load-use hazard predicate.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_e;

    localparam logic [4:0] REG_X0 = 5'd0;
    localparam int         FCNT_W = 3;

    // rs1 is compared even for formats without rs1; a spurious stall only costs a cycle
    function automatic logic load_use(
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       use_rs2,
        input logic [4:0] ex_rd,
        input logic       ex_is_load
    );
        return ex_is_load && (ex_rd != REG_X0) &&
               ((ex_rd == rs1) || (use_rs2 && (ex_rd == rs2)));
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of hazard-control signals between the pipeline stages and the sequencer.
// The i_/o_ prefixes are from the sequencer's point of view.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       i_dec_rs1;
    logic [4:0]       i_dec_rs2;
    logic             i_dec_use_rs2;
    logic [4:0]       i_ex_rd;
    logic             i_ex_is_load;
    logic             i_ex_redirect;
    logic             i_mem_busy;
    logic             o_fetch_stall;
    logic             o_dec_stall;
    logic             o_dec_flush;
    logic             o_ex_bubble;
    logic             o_ex_hold;
    logic [1:0]       o_state;
    logic [CNT_W-1:0] o_lu_cnt;
    logic [CNT_W-1:0] o_mem_cnt;
    logic [CNT_W-1:0] o_flush_cnt;

    modport slave (
        input  i_dec_rs1, i_dec_rs2, i_dec_use_rs2, i_ex_rd, i_ex_is_load,
               i_ex_redirect, i_mem_busy,
        output o_fetch_stall, o_dec_stall, o_dec_flush, o_ex_bubble, o_ex_hold,
               o_state, o_lu_cnt, o_mem_cnt, o_flush_cnt
    );

    modport master (
        output i_dec_rs1, i_dec_rs2, i_dec_use_rs2, i_ex_rd, i_ex_is_load,
               i_ex_redirect, i_mem_busy,
        input  o_fetch_stall, o_dec_stall, o_dec_flush, o_ex_bubble, o_ex_hold,
               o_state, o_lu_cnt, o_mem_cnt, o_flush_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Performance event counter that sticks at all-ones instead of wrapping.
module pipeline_hazard_ctrl_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, memory-wait
// holds and multi-cycle flushes after an execute redirect, with perf counters.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    pipeline_hazard_ctrl_if.slave bus
);
    localparam logic [FCNT_W-1:0] FLUSH_RELOAD = FCNT_W'(FLUSH_CYCLES - 1);
    localparam state_e            ST_AFTER_REDIRECT = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;

    state_e            r_state;
    state_e            w_state_next;
    logic [FCNT_W-1:0] r_fcnt;
    logic [FCNT_W-1:0] w_fcnt_next;
    logic              w_lu;
    logic              w_fetch_stall;
    logic              w_dec_stall;
    logic              w_dec_flush;
    logic              w_ex_bubble;
    logic              w_ex_hold;
    logic [2:0]        w_cnt_inc;
    logic [CNT_W-1:0]  w_cnt_val [3];

    assign w_lu = load_use(bus.i_dec_rs1, bus.i_dec_rs2, bus.i_dec_use_rs2,
                           bus.i_ex_rd, bus.i_ex_is_load);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_RUN;
            r_fcnt  <= '0;
        end else begin
            r_state <= w_state_next;
            r_fcnt  <= w_fcnt_next;
        end
    end

    // RUN and MEM_WAIT share transitions; MEM_WAIT mainly makes the wait visible on o_state
    always_comb begin
        w_state_next = r_state;
        w_fcnt_next  = r_fcnt;
        case (r_state)
            ST_FLUSH: begin
                if (bus.i_mem_busy) begin
                    w_state_next = ST_FLUSH;
                end else if (bus.i_ex_redirect) begin
                    w_fcnt_next  = FLUSH_RELOAD;
                    w_state_next = ST_AFTER_REDIRECT;
                end else if (r_fcnt <= FCNT_W'(1)) begin
                    w_fcnt_next  = '0;
                    w_state_next = ST_RUN;
                end else begin
                    w_fcnt_next  = r_fcnt - FCNT_W'(1);
                end
            end
            default: begin
                if (bus.i_mem_busy) begin
                    w_state_next = ST_MEM_WAIT;
                end else if (bus.i_ex_redirect) begin
                    w_fcnt_next  = FLUSH_RELOAD;
                    w_state_next = ST_AFTER_REDIRECT;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
        endcase
    end

    // Index 0: load-use, 1: memory wait, 2: redirect events
    always_comb begin
        w_fetch_stall = 1'b0;
        w_dec_stall   = 1'b0;
        w_dec_flush   = 1'b0;
        w_ex_bubble   = 1'b0;
        w_ex_hold     = 1'b0;
        w_cnt_inc     = 3'b000;
        if (rstn) begin
            w_cnt_inc[1] = bus.i_mem_busy;
            case (r_state)
                ST_FLUSH: begin
                    w_dec_flush = 1'b1;
                    if (bus.i_mem_busy) begin
                        w_fetch_stall = 1'b1;
                        w_dec_stall   = 1'b1;
                        w_ex_hold     = 1'b1;
                    end else if (bus.i_ex_redirect) begin
                        w_cnt_inc[2] = 1'b1;
                    end
                end
                default: begin
                    if (bus.i_mem_busy) begin
                        w_fetch_stall = 1'b1;
                        w_dec_stall   = 1'b1;
                        w_ex_hold     = 1'b1;
                    end else if (bus.i_ex_redirect) begin
                        w_dec_flush  = 1'b1;
                        w_cnt_inc[2] = 1'b1;
                    end else if (w_lu) begin
                        w_fetch_stall = 1'b1;
                        w_dec_stall   = 1'b1;
                        w_ex_bubble   = 1'b1;
                        w_cnt_inc[0]  = 1'b1;
                    end
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_perf
            pipeline_hazard_ctrl_sat_counter #(.CNT_W(CNT_W)) u_cnt (
                .clk   (clk),
                .rstn  (rstn),
                .i_inc (w_cnt_inc[gi]),
                .o_cnt (w_cnt_val[gi])
            );
        end
    endgenerate

    assign bus.o_fetch_stall = w_fetch_stall;
    assign bus.o_dec_stall   = w_dec_stall;
    assign bus.o_dec_flush   = w_dec_flush;
    assign bus.o_ex_bubble   = w_ex_bubble;
    assign bus.o_ex_hold     = w_ex_hold;
    assign bus.o_state       = r_state;
    assign bus.o_lu_cnt      = w_cnt_val[0];
    assign bus.o_mem_cnt     = w_cnt_val[1];
    assign bus.o_flush_cnt   = w_cnt_val[2];
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: each stimulus cycle queues its expected outputs; a monitor on the
// falling edge pops and compares them against the sequencer.
module tb_pipeline_hazard_ctrl;
    logic clk  = 1'b0;
    logic rstn = 1'b0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.CNT_W(32)) bus ();

    pipeline_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(32)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    typedef struct {
        string tag;
        bit    fs, ds, df, eb, eh;
        int    st, lu, mem, fl;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input string nm, input logic [31:0] act, input int req);
        n_checks++;
        if (act !== 32'(req)) begin
            n_fail++;
            $display("FAIL %s.%s: got %0d, expected %0d", tag, nm, act, req);
        end
    endtask

    // One cycle: drive inputs just after the rising edge, queue the expected response
    task automatic t(input string tag, input bit rn,
                     input int rs1, input int rs2, input bit u2, input int rd,
                     input bit ld, input bit rdr, input bit bsy,
                     input bit fs, input bit ds, input bit df, input bit eb, input bit eh,
                     input int st, input int lu, input int mem, input int fl);
        exp_t e;
        @(posedge clk);
        #1;
        rstn              = rn;
        bus.i_dec_rs1     = rs1[4:0];
        bus.i_dec_rs2     = rs2[4:0];
        bus.i_dec_use_rs2 = u2;
        bus.i_ex_rd       = rd[4:0];
        bus.i_ex_is_load  = ld;
        bus.i_ex_redirect = rdr;
        bus.i_mem_busy    = bsy;
        e.tag = tag; e.fs = fs; e.ds = ds; e.df = df; e.eb = eb; e.eh = eh;
        e.st = st; e.lu = lu; e.mem = mem; e.fl = fl;
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                $display("txn %-12s fs=%0b ds=%0b df=%0b eb=%0b eh=%0b st=%0d lu=%0d mem=%0d fl=%0d",
                         e.tag, bus.o_fetch_stall, bus.o_dec_stall, bus.o_dec_flush,
                         bus.o_ex_bubble, bus.o_ex_hold, bus.o_state,
                         bus.o_lu_cnt, bus.o_mem_cnt, bus.o_flush_cnt);
                chk(e.tag, "fetch_stall", 32'(bus.o_fetch_stall), int'(e.fs));
                chk(e.tag, "dec_stall",   32'(bus.o_dec_stall),   int'(e.ds));
                chk(e.tag, "dec_flush",   32'(bus.o_dec_flush),   int'(e.df));
                chk(e.tag, "ex_bubble",   32'(bus.o_ex_bubble),   int'(e.eb));
                chk(e.tag, "ex_hold",     32'(bus.o_ex_hold),     int'(e.eh));
                chk(e.tag, "state",       32'(bus.o_state),       e.st);
                chk(e.tag, "lu_cnt",      bus.o_lu_cnt,           e.lu);
                chk(e.tag, "mem_cnt",     bus.o_mem_cnt,          e.mem);
                chk(e.tag, "flush_cnt",   bus.o_flush_cnt,        e.fl);
            end
        end
    end

    initial begin : stimulus
        int waited;
        bus.i_dec_rs1 = '0; bus.i_dec_rs2 = '0; bus.i_dec_use_rs2 = 1'b0;
        bus.i_ex_rd = '0; bus.i_ex_is_load = 1'b0; bus.i_ex_redirect = 1'b0;
        bus.i_mem_busy = 1'b0;
        //  tag           rn rs1 rs2 u2 rd ld rdr bsy  fs ds df eb eh st lu mem fl
        t("reset",        0, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0, 0);
        t("idle0",        1, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0, 0);
        // load-use on rs1, then clears
        t("lu_rs1",       1, 5, 0, 0, 5, 1, 0, 0,    1, 1, 0, 1, 0, 0, 0, 0, 0);
        t("lu_clear",     1, 5, 0, 0, 5, 0, 0, 0,    0, 0, 0, 0, 0, 0, 1, 0, 0);
        t("lu_x0",        1, 0, 0, 0, 0, 1, 0, 0,    0, 0, 0, 0, 0, 0, 1, 0, 0);
        t("rs2_nouse",    1, 1, 7, 0, 7, 1, 0, 0,    0, 0, 0, 0, 0, 0, 1, 0, 0);
        t("rs2_use",      1, 1, 7, 1, 7, 1, 0, 0,    1, 1, 0, 1, 0, 0, 1, 0, 0);
        t("idle1",        1, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 2, 0, 0);
        // redirect: two flush cycles
        t("redir",        1, 0, 0, 0, 0, 0, 1, 0,    0, 0, 1, 0, 0, 0, 2, 0, 0);
        t("flush1",       1, 0, 0, 0, 0, 0, 0, 0,    0, 0, 1, 0, 0, 2, 2, 0, 1);
        t("post_flush",   1, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 2, 0, 1);
        // second redirect inside FLUSH extends to three cycles
        t("redir_a",      1, 0, 0, 0, 0, 0, 1, 0,    0, 0, 1, 0, 0, 0, 2, 0, 1);
        t("redir_b",      1, 0, 0, 0, 0, 0, 1, 0,    0, 0, 1, 0, 0, 2, 2, 0, 2);
        t("flush_ext",    1, 0, 0, 0, 0, 0, 0, 0,    0, 0, 1, 0, 0, 2, 2, 0, 3);
        t("post_ext",     1, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 2, 0, 3);
        // memory busy four cycles; redirect during busy ignored
        t("busy1",        1, 0, 0, 0, 0, 0, 0, 1,    1, 1, 0, 0, 1, 0, 2, 0, 3);
        t("busy2_redir",  1, 0, 0, 0, 0, 0, 1, 1,    1, 1, 0, 0, 1, 1, 2, 1, 3);
        t("busy3",        1, 0, 0, 0, 0, 0, 0, 1,    1, 1, 0, 0, 1, 1, 2, 2, 3);
        t("busy4",        1, 0, 0, 0, 0, 0, 0, 1,    1, 1, 0, 0, 1, 1, 2, 3, 3);
        t("busy_end",     1, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 1, 2, 4, 3);
        t("post_busy",    1, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 2, 4, 3);
        // redirect beats load-use
        t("lu_and_redir", 1, 5, 0, 0, 5, 1, 1, 0,    0, 0, 1, 0, 0, 0, 2, 4, 3);
        t("flush_lu_rd",  1, 0, 0, 0, 0, 0, 0, 0,    0, 0, 1, 0, 0, 2, 2, 4, 4);
        t("idle2",        1, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 2, 4, 4);
        // busy inside FLUSH freezes the count; load-use suppressed while flushing
        t("redir3",       1, 0, 0, 0, 0, 0, 1, 0,    0, 0, 1, 0, 0, 0, 2, 4, 4);
        t("flush_busy",   1, 5, 0, 0, 5, 1, 0, 1,    1, 1, 1, 0, 1, 2, 2, 4, 5);
        t("flush_lu",     1, 5, 0, 0, 5, 1, 0, 0,    0, 0, 1, 0, 0, 2, 2, 5, 5);
        t("idle3",        1, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 2, 5, 5);
        // leaving MEM_WAIT evaluates load-use in the same cycle
        t("busy5",        1, 0, 0, 0, 0, 0, 0, 1,    1, 1, 0, 0, 1, 0, 2, 5, 5);
        t("mw_exit_lu",   1, 5, 0, 0, 5, 1, 0, 0,    1, 1, 0, 1, 0, 1, 2, 6, 5);
        t("idle4",        1, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 3, 6, 5);
        // reset in the middle of a flush
        t("redir4",       1, 0, 0, 0, 0, 0, 1, 0,    0, 0, 1, 0, 0, 0, 3, 6, 5);
        t("rst_mid",      0, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0, 0);
        t("rst_hold",     0, 5, 0, 0, 5, 1, 1, 1,    0, 0, 0, 0, 0, 0, 0, 0, 0);
        t("rst_rel",      1, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0, 0);
        t("idle5",        1, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0, 0);

        waited = 0;
        while (q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        if (q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d queued transactions left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage in-order RV32I pipeline (fetch, decode, execute, memory, writeback).
- Detects load-use hazards between the decode buffer and the execute stage.
- Holds the pipeline while the memory stage is busy.
- Sequences multi-cycle flushes after an execute-stage redirect, i.e. a mispredicted branch or jump.
- Drives the decode unit's i_exec_stall / i_exec_flush inputs, the fetch stall and the execute bubble insert, and keeps hazard performance counters.

Parameters:
FLUSH_CYCLES, 2, cycles o_dec_flush stays high per redirect, covering fetch latency; legal range 1..7.
CNT_W, 32, width of the performance counters.

Ports:
clk  in  1  clock
rstn  in  1  reset; asynchronous, active-low
i_dec_rs1  in  5  rs1 of the instruction held in the decode buffer
i_dec_rs2  in  5  rs2 of the instruction held in the decode buffer
i_dec_use_rs2  in  1  decode instruction reads rs2 (R/S/B types)
i_ex_rd  in  5  destination register of the execute-stage instruction
i_ex_is_load  in  1  execute-stage instruction is a load
i_ex_redirect  in  1  execute resolved a mispredict; one-cycle pulse
i_mem_busy  in  1  memory stage waiting on the data bus
o_fetch_stall  out  1  hold the PC and the fetch output
o_dec_stall  out  1  to decode i_exec_stall
o_dec_flush  out  1  to decode i_exec_flush
o_ex_bubble  out  1  execute latches a NOP instead of the decode output
o_ex_hold  out  1  execute/memory registers hold
o_state  out  2  current FSM state, for debug
o_lu_cnt  out  CNT_W  load-use stall cycles
o_mem_cnt  out  CNT_W  memory-wait cycles
o_flush_cnt  out  CNT_W  redirect events

Behaviour:
- Reset (async, rstn low): state=RUN, flush counter=0, all perf counters=0. Every control output is low while rstn is low.
- FSM states: RUN=0, MEM_WAIT=1, FLUSH=2 (value 3 unused; decodes as RUN).
- Load-use hazard (combinational): lu = i_ex_is_load & (i_ex_rd!=0) & ((i_ex_rd==i_dec_rs1) | (i_dec_use_rs2 & i_ex_rd==i_dec_rs2)). rs1 is always compared; a false positive costs one cycle and is acceptable.
- Priority within a cycle: i_mem_busy > i_ex_redirect > active flush > lu.
- RUN state:
  - i_mem_busy=1: o_fetch_stall=o_dec_stall=o_ex_hold=1 in the same cycle; next state MEM_WAIT.
  - else i_ex_redirect=1: o_dec_flush=1 in the same cycle, fetch not stalled; load counter with FLUSH_CYCLES-1; next state FLUSH if FLUSH_CYCLES>1, else RUN. o_flush_cnt+1.
  - else lu=1: o_fetch_stall=o_dec_stall=o_ex_bubble=1 for exactly that cycle; o_lu_cnt+1. The hazard clears once the bubble reaches execute; no extra state.
  - else: all outputs low.
- MEM_WAIT state:
  - Stall outputs (o_fetch_stall, o_dec_stall, o_ex_hold) stay high while i_mem_busy=1; o_mem_cnt+1 per cycle, including the entry cycle.
  - On i_mem_busy=0, outputs drop in that same cycle and the state returns to RUN; normal RUN evaluation applies in that cycle.
  - i_ex_redirect is ignored while i_mem_busy=1, because execute is held and the redirect re-presents later.
- FLUSH state:
  - o_dec_flush=1, lu stalls suppressed (the decode buffer holds a NOP).
  - Counter decrements each cycle; return to RUN when it reaches 1 → 0.
  - A new i_ex_redirect reloads the counter to FLUSH_CYCLES-1 and counts a new event.
  - i_mem_busy in FLUSH: stall outputs and o_dec_flush both high; the flush counter freezes; the state stays FLUSH.
- Perf counters saturate at all-ones and never wrap.
- Outputs are combinational from the state plus the current inputs, giving zero-latency stalls. All state updates happen on the clk rising edge.
- Reset mid-flush or mid-wait: immediate return to RUN with outputs low. No partial flush resumes.

Decomposition:
- Shared package/header (macros.hv): state encodings (ST_RUN, ST_MEM_WAIT, ST_FLUSH) and the x0 register index constant.
- One natural sub-module, sat_counter (CNT_W parameter, inc, async clear), instantiated three times for the perf counters.

Test Plan:
1. Load rd=5 in execute, decode rs1=5 → one cycle with o_fetch_stall=o_dec_stall=o_ex_bubble=1. Next cycle i_ex_is_load=0 → all low. o_lu_cnt=1.
2. Load rd=0, decode rs1=0 → no stall. Load rd=7, rs2=7 with i_dec_use_rs2=0 → no stall; with i_dec_use_rs2=1 → stall.
3. i_ex_redirect pulse, FLUSH_CYCLES=2 → o_dec_flush high 2 cycles (RUN→FLUSH→RUN), o_flush_cnt=1. Second redirect in the FLUSH cycle → flush extends to 3 total cycles, o_flush_cnt=2.
4. i_mem_busy high 4 cycles → stall/hold high exactly 4 cycles, o_mem_cnt=4, state 1 then 0. A redirect asserted during busy → no flush.
5. Simultaneous lu=1, i_ex_redirect=1 → only o_dec_flush, no bubble, o_lu_cnt unchanged.
6. rstn asserted mid-FLUSH → outputs low immediately, counters 0, o_state=0 after release.
